// File: rtl/styler_sgr_decoder_if.sv
// Byte-stream bundle between the host byte source, the SGR decoder and the character store.
//   in_data/in_valid/in_ready     : input byte stream (master drives data/valid)
//   out_data/out_attr/out_valid/out_ready : forwarded byte plus attribute snapshot
// master = byte source + downstream sink side; slave = decoder side.
interface styler_sgr_decoder_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [16:0] out_attr;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_attr, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_attr, out_valid
  );
endinterface

// File: rtl/styler_sgr_decoder.sv
// SGR decoder: parses ESC [ p;p;... m sequences into 17 attribute flags and forwards every
// non-sequence byte together with the attribute snapshot that applies to it.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   bus        slave modport: in_* byte stream in, out_* forwarded byte + attr snapshot out
//   attr       live committed attribute register
//   seq_error  one-cycle pulse when a sequence is discarded
// Optional feature: define STYLER_SGR_COLON_EN to accept "4:n" underline-style sub-params.
module styler_sgr_decoder #(
  parameter int unsigned MAX_PARAMS = 16,
  parameter int unsigned PARAM_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  styler_sgr_decoder_if.slave  bus,
  output logic [16:0]          attr,
  output logic                 seq_error
);

  localparam int unsigned CntW = $clog2(MAX_PARAMS + 1);
  localparam int unsigned SumW = PARAM_W + 5;
  typedef logic [SumW-1:0] sum_t;

  localparam logic [16:0] UlMask = 17'h00700;
  localparam logic [16:0] StMask = 17'h03800;
  localparam logic [16:0] OvMask = 17'h1C000;

  typedef enum logic [1:0] {StIdle, StEsc, StCsi} state_e;

  state_e             state_q, state_d;
  logic [16:0]        attr_q, attr_d, work_q, work_d, out_attr_q, out_attr_d;
  logic [PARAM_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d, seq_error_q, seq_error_d;
  logic               in_ready, accept;
  logic [7:0]         b;
  logic [16:0]        fin_attr;
`ifdef STYLER_SGR_COLON_EN
  logic               sub_q, sub_d;
  logic [PARAM_W-1:0] main_q, main_d;
`endif

  // Apply one SGR parameter; group variants are mutually exclusive.
  function automatic logic [16:0] apply_sgr(input logic [16:0] a, input logic [PARAM_W-1:0] p);
    logic [16:0] r;
    r = a;
    case (32'(p))
      0:   r = '0;
      1:   r[0] = 1'b1;
      2:   r[1] = 1'b1;
      3:   begin r[2] = 1'b1; r[3] = 1'b0; end
      127: begin r[3] = 1'b1; r[2] = 1'b0; end
      4:   r = (a & ~UlMask) | 17'h00100;
      21:  r = (a & ~UlMask) | 17'h00200;
      120: r = (a & ~UlMask) | 17'h00400;
      5:   r[4] = 1'b1;
      6:   r[5] = 1'b1;
      7:   r[6] = 1'b1;
      8:   r[7] = 1'b1;
      9:   r = (a & ~StMask) | 17'h00800;
      121: r = (a & ~StMask) | 17'h01000;
      122: r = (a & ~StMask) | 17'h02000;
      53:  r = (a & ~OvMask) | 17'h04000;
      123: r = (a & ~OvMask) | 17'h08000;
      124: r = (a & ~OvMask) | 17'h10000;
      22:  r[1:0] = 2'b00;
      23:  r[3:2] = 2'b00;
      24:  r = a & ~UlMask;
      25:  r[4] = 1'b0;
      26:  r[5] = 1'b0;
      27:  r[6] = 1'b0;
      28:  r[7] = 1'b0;
      29:  r = a & ~StMask;
      55:  r = a & ~OvMask;
      default: ;
    endcase
    return r;
  endfunction

  // Decimal accumulate, saturating at all-ones.
  function automatic logic [PARAM_W-1:0] sat_acc(input logic [PARAM_W-1:0] acc,
                                                 input logic [3:0] d);
    sum_t s;
    s = sum_t'(acc) * sum_t'(10) + sum_t'(d);
    if (s > sum_t'({PARAM_W{1'b1}})) return '1;
    return s[PARAM_W-1:0];
  endfunction

  assign b        = bus.in_data;
  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  // Work attributes with the current parameter folded in (params past MAX_PARAMS dropped).
  always_comb begin
    fin_attr = work_q;
    if (32'(cnt_q) < MAX_PARAMS) begin
`ifdef STYLER_SGR_COLON_EN
      if (sub_q && 32'(main_q) == 32'd4) begin
        case (32'(acc_q))
          0:       fin_attr = work_q & ~UlMask;
          1:       fin_attr = (work_q & ~UlMask) | 17'h00100;
          2:       fin_attr = (work_q & ~UlMask) | 17'h00200;
          3:       fin_attr = (work_q & ~UlMask) | 17'h00400;
          default: ;
        endcase
      end else if (sub_q) begin
        // Sub-params on anything but 4 are dropped; the main param still applies.
        fin_attr = apply_sgr(work_q, main_q);
      end else begin
        fin_attr = apply_sgr(work_q, acc_q);
      end
`else
      fin_attr = apply_sgr(work_q, acc_q);
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    attr_d      = attr_q;
    work_d      = work_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_attr_d  = out_attr_q;
    out_valid_d = out_valid_q;
    seq_error_d = 1'b0;
`ifdef STYLER_SGR_COLON_EN
    sub_d       = sub_q;
    main_d      = main_q;
`endif
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      case (state_q)
        StIdle: begin
          if (b == 8'h1B) begin
            state_d = StEsc;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = b;
            out_attr_d  = attr_q;
          end
        end
        StEsc: begin
          if (b == 8'h5B) begin
            state_d = StCsi;
            work_d  = attr_q;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef STYLER_SGR_COLON_EN
            sub_d   = 1'b0;
            main_d  = '0;
`endif
          end else begin
            state_d     = StIdle;
            seq_error_d = 1'b1;
          end
        end
        StCsi: begin
          if (b >= 8'h30 && b <= 8'h39) begin
            acc_d = sat_acc(acc_q, b[3:0]);
          end else if (b == 8'h3B) begin
            work_d = fin_attr;
            if (32'(cnt_q) < MAX_PARAMS) cnt_d = cnt_q + CntW'(1);
            acc_d = '0;
`ifdef STYLER_SGR_COLON_EN
            sub_d = 1'b0;
          end else if (b == 8'h3A) begin
            // Later sub-params overwrite earlier ones; the main param is latched once.
            if (!sub_q) main_d = acc_q;
            sub_d = 1'b1;
            acc_d = '0;
`endif
          end else if (b == 8'h6D) begin
            attr_d  = fin_attr;
            state_d = StIdle;
          end else if (b >= 8'h40 && b <= 8'h7E) begin
            state_d = StIdle;
          end else if (b == 8'h1B) begin
            state_d     = StEsc;
            seq_error_d = 1'b1;
          end else begin
            state_d     = StIdle;
            seq_error_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      attr_q      <= '0;
      work_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_attr_q  <= '0;
      out_valid_q <= 1'b0;
      seq_error_q <= 1'b0;
`ifdef STYLER_SGR_COLON_EN
      sub_q       <= 1'b0;
      main_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      attr_q      <= attr_d;
      work_q      <= work_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_attr_q  <= out_attr_d;
      out_valid_q <= out_valid_d;
      seq_error_q <= seq_error_d;
`ifdef STYLER_SGR_COLON_EN
      sub_q       <= sub_d;
      main_q      <= main_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_attr  = out_attr_q;
  assign bus.out_valid = out_valid_q;
  assign attr          = attr_q;
  assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_styler_sgr_decoder.sv
// Bench for styler_sgr_decoder: directed cases followed by randomized segments (plain bytes,
// SGR sequences, aborted sequences) scored against a parameter-list level reference model.
module tb_styler_sgr_decoder;
  logic        clk, rst;
  logic [16:0] attr;
  logic        seq_error;

  styler_sgr_decoder_if bus();

  styler_sgr_decoder #(.MAX_PARAMS(16), .PARAM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .attr      (attr),
    .seq_error (seq_error)
  );

  int          checks = 0, errors = 0, exp_err = 0, err_seen = 0, rdy_mode = 0;
  logic [16:0] model_attr;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;
  int          pv[$];
  int          codes[33] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 21, 22, 23, 24, 25, 26, 27, 28, 29,
                             53, 55, 120, 121, 122, 123, 124, 127, 10, 30, 54, 255, 256, 999};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attribute rules as set/clear masks per SGR code.
  function automatic logic [16:0] m_apply(input logic [16:0] a, input int p);
    logic [16:0] s, c;
    s = '0;
    c = '0;
    case (p)
      0:   c = '1;
      1:   s = 17'h00001;
      2:   s = 17'h00002;
      3:   begin s = 17'h00004; c = 17'h00008; end
      127: begin s = 17'h00008; c = 17'h00004; end
      4:   begin s = 17'h00100; c = 17'h00700; end
      21:  begin s = 17'h00200; c = 17'h00700; end
      120: begin s = 17'h00400; c = 17'h00700; end
      5:   s = 17'h00010;
      6:   s = 17'h00020;
      7:   s = 17'h00040;
      8:   s = 17'h00080;
      9:   begin s = 17'h00800; c = 17'h03800; end
      121: begin s = 17'h01000; c = 17'h03800; end
      122: begin s = 17'h02000; c = 17'h03800; end
      53:  begin s = 17'h04000; c = 17'h1C000; end
      123: begin s = 17'h08000; c = 17'h1C000; end
      124: begin s = 17'h10000; c = 17'h1C000; end
      22:  c = 17'h00003;
      23:  c = 17'h0000C;
      24:  c = 17'h00700;
      25:  c = 17'h00010;
      26:  c = 17'h00020;
      27:  c = 17'h00040;
      28:  c = 17'h00080;
      29:  c = 17'h03800;
      55:  c = 17'h1C000;
      default: ;
    endcase
    return (a & ~c) | s;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Output scoreboard and seq_error pulse counter.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (seq_error) err_seen++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL out_unexpected data=%h attr=%h", bus.out_data, bus.out_attr);
        end else begin
          mon_e = exp_q.pop_front();
          assert ({bus.out_data, bus.out_attr} === mon_e) else begin
            errors++;
            $error("FAIL out_byte got=%h/%h exp=%h/%h", bus.out_data, bus.out_attr,
                   mon_e[24:17], mon_e[16:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $error("FAIL send_timeout byte=%h", b);
        done = 1'b1;
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_num(input int v, input bit allow_empty);
    int d[$];
    if (!(v == 0 && allow_empty && $urandom_range(0, 1) == 1)) begin
      if ($urandom_range(0, 7) == 0) send(8'h30);
      do begin
        d.push_front(v % 10);
        v = v / 10;
      end while (v > 0);
      foreach (d[i]) send(8'(48 + d[i]));
    end
  endtask

  task automatic send_seq(input logic [7:0] term);
    send(8'h1B);
    send(8'h5B);
    foreach (pv[i]) begin
      if (i > 0) send(8'h3B);
      send_num(pv[i], 1'b1);
    end
    send(term);
  endtask

  task automatic model_sgr();
    for (int i = 0; i < pv.size() && i < 16; i++) model_attr = m_apply(model_attr, sat(pv[i]));
  endtask

  task automatic plain(input logic [7:0] b);
    exp_q.push_back({b, model_attr});
    send(b);
  endtask

  task automatic drain();
    rdy_mode = 0;
    repeat (4) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic check_attr(input string tag);
    checks++;
    assert (attr === model_attr) else begin
      errors++;
      $error("FAIL %s attr got=%h exp=%h", tag, attr, model_attr);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         kind, np;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    model_attr   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_attr", 32'(attr), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_attr", 32'(bus.out_attr), 0);
    chk("rst_seq_error", 32'(seq_error), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // ESC[1;4mA
    pv = '{1, 4};
    send_seq(8'h6D);
    model_sgr();
    chk("bold_ul_attr", 32'(attr), 32'h00101);
    plain(8'h41);
    drain();

    // ESC[21m replaces underline with double underline
    pv = '{21};
    send_seq(8'h6D);
    model_sgr();
    chk("dbl_ul_attr", 32'(attr), 32'h00201);

    // ESC[7;9 CAN aborts
    pv = '{7, 9};
    exp_err++;
    send_seq(8'h18);
    chk("can_pulse_hi", 32'(seq_error), 1);
    @(posedge clk);
    #1;
    chk("can_pulse_lo", 32'(seq_error), 0);
    chk("can_attr_kept", 32'(attr), 32'h00201);
    plain(8'h42);
    drain();

    // Back-pressure: 'x' held, 'y' stalled then accepted
    rdy_mode = 2;
    plain(8'h78);
    exp_q.push_back({8'h79, model_attr});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_data   = 8'h79;
      bus.in_valid  = 1'b1;
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_data", 32'(bus.out_data), 32'h78);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();

    // Saturation: 999 -> 255 ignored
    pv = '{0};
    send_seq(8'h6D);
    model_sgr();
    pv = '{999, 1};
    send_seq(8'h6D);
    model_sgr();
    chk("sat_attr", 32'(attr), 32'h00001);

    // Empty middle param clears: ESC[1;;4m
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h3B); send(8'h3B); send(8'h34); send(8'h6D);
    pv = '{1, 0, 4};
    model_sgr();
    chk("empty_param_attr", 32'(attr), 32'h00100);

    // ESC[m clears
    send(8'h1B); send(8'h5B); send(8'h6D);
    model_attr = '0;
    chk("esc_m_attr", 32'(attr), 0);

    // 16 params all applied, 17th ignored
    pv.delete();
    repeat (14) pv.push_back(0);
    pv.push_back(4);
    pv.push_back(1);
    send_seq(8'h6D);
    model_sgr();
    chk("p16_attr", 32'(attr), 32'h00101);
    pv.delete();
    repeat (15) pv.push_back(0);
    pv.push_back(4);
    pv.push_back(1);
    send_seq(8'h6D);
    model_sgr();
    chk("p17_attr", 32'(attr), 32'h00100);

    // Other final byte: silent discard
    pv = '{1};
    send_seq(8'h48);
    check_attr("final_h_attr");

    // ESC inside CSI restarts: ESC[1 ESC[4;53m
    pv = '{1};
    exp_err++;
    send_seq(8'h1B);
    send(8'h5B); send(8'h34); send(8'h3B); send(8'h35); send(8'h33); send(8'h6D);
    pv = '{4, 53};
    model_sgr();
    chk("esc_restart_attr", 32'(attr), 32'h04100);

    // ESC x: both discarded
    exp_err++;
    send(8'h1B);
    send(8'h78);
    check_attr("esc_x_attr");
    plain(8'h5A);
    drain();

    // Colon sub-parameter
    pv = '{0};
    send_seq(8'h6D);
    model_sgr();
    send(8'h1B); send(8'h5B); send(8'h34); send(8'h3A);
`ifdef STYLER_SGR_COLON_EN
    send(8'h33); send(8'h6D);
    model_attr = 17'h00400;
    chk("colon_attr", 32'(attr), 32'h00400);
`else
    exp_err++;
    plain(8'h33);
    plain(8'h6D);
    drain();
    chk("colon_attr", 32'(attr), 0);
`endif

    // Reset clears pending output and drops a partial sequence
    rdy_mode = 2;
    send(8'h78);
    @(negedge clk);
    #1;
    chk("pend_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pend_valid", 32'(bus.out_valid), 0);
    chk("rst_attr_clr", 32'(attr), 0);
    model_attr = '0;
    rdy_mode = 0;
    pv = '{1};
    send(8'h1B); send(8'h5B); send(8'h31);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    plain(8'h6D);
    drain();
    check_attr("rst_mid_seq_attr");

    // Randomized segments
    for (int s = 0; s < 250; s++) begin
      rdy_mode = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      pv.delete();
      np = $urandom_range(1, 18);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 3) == 0) pv.push_back($urandom_range(0, 1100));
        else pv.push_back(codes[$urandom_range(0, 32)]);
      end
      if (kind <= 4) begin
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'h1B) rb = 8'h41;
        plain(rb);
      end else if (kind <= 7) begin
        send_seq(8'h6D);
        model_sgr();
      end else if (kind == 8) begin
        if ($urandom_range(0, 1) == 1) begin
          exp_err++;
          send_seq($urandom_range(0, 1) == 1 ? 8'h18 : 8'h1A);
        end else begin
          rb = 8'(64 + $urandom_range(0, 62));
          if (rb == 8'h6D) rb = 8'h48;
          send_seq(rb);
        end
      end else begin
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'h5B || rb == 8'h1B) rb = 8'h61;
        exp_err++;
        send(8'h1B);
        send(rb);
      end
      check_attr("rand_attr");
    end

    drain();
    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("seq_error_count", 32'(err_seen), 32'(exp_err));
    check_attr("final_attr");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
